// File: rtl/multiword_subtractor_if.sv
// rtl/multiword_subtractor_if.sv - request/result bundle for the limb-serial subtractor
interface multiword_subtractor_if #(
  parameter int N     = 4,
  parameter int WORDS = 4
);
  logic               i_start;
  logic [N*WORDS-1:0] i_minuend;
  logic [N*WORDS-1:0] i_subtrahend;
  logic               i_borrow;
  logic               o_ready;
  logic               o_done;
  logic [N*WORDS-1:0] o_difference;
  logic               o_borrow;
  logic               o_overflow;
  logic               o_zero;

  modport master (
    output i_start, i_minuend, i_subtrahend, i_borrow,
    input  o_ready, o_done, o_difference, o_borrow, o_overflow, o_zero
  );

  modport slave (
    input  i_start, i_minuend, i_subtrahend, i_borrow,
    output o_ready, o_done, o_difference, o_borrow, o_overflow, o_zero
  );
endinterface

// File: rtl/multiword_subtractor.sv
// rtl/multiword_subtractor.sv - limb-serial multi-precision subtractor with borrow chaining
module multiword_subtractor #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  multiword_subtractor_if.slave  bus
);
  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  state_t        state_next;
  logic          accept;
  logic          last;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          borrow_reg;
  logic [W-1:0]  res_reg;
  logic [W-1:0]  res_next;
  logic [N:0]    limb_diff;
  logic [N-1:0]  a_limb;
  logic [N-1:0]  b_limb;

  logic          done_q;
  logic [W-1:0]  diff_q;
  logic          borrow_q;
  logic          overflow_q;
  logic          zero_q;

  assign last = (idx == LAST_IDX);

  // State register; reset discards any in-flight operation.
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state: accept a request only while idle, return to idle after the last limb.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_start) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One N-bit subtract per cycle on the current limb, with the limb merged into the running result.
  always_comb begin
    a_limb    = a_reg[int'(idx) * N +: N];
    b_limb    = b_reg[int'(idx) * N +: N];
    limb_diff = {1'b0, a_limb} - {1'b0, b_limb} - {{N{1'b0}}, borrow_reg};
    res_next  = res_reg;
    res_next[int'(idx) * N +: N] = limb_diff[N-1:0];
  end

  // Operand latching, limb stepping and publication of the final flags.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      idx        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      borrow_reg <= 1'b0;
      res_reg    <= '0;
      done_q     <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        a_reg      <= bus.i_minuend;
        b_reg      <= bus.i_subtrahend;
        borrow_reg <= bus.i_borrow;
        idx        <= '0;
      end else if (state == BUSY) begin
        res_reg    <= res_next;
        borrow_reg <= limb_diff[N];
        if (last) begin
          idx        <= '0;
          done_q     <= 1'b1;
          diff_q     <= res_next;
          borrow_q   <= limb_diff[N];
          overflow_q <= (a_reg[W-1] != b_reg[W-1]) && (res_next[W-1] != a_reg[W-1]);
          zero_q     <= (res_next == '0);
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  assign bus.o_ready      = (state == IDLE);
  assign bus.o_done       = done_q;
  assign bus.o_difference = diff_q;
  assign bus.o_borrow     = borrow_q;
  assign bus.o_overflow   = overflow_q;
  assign bus.o_zero       = zero_q;
endmodule

// File: tb/tb_multiword_subtractor.sv
// tb/tb_multiword_subtractor.sv - directed bench for the limb-serial subtractor
module tb_multiword_subtractor;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  multiword_subtractor_if #(.N(4), .WORDS(4)) u_if ();
  multiword_subtractor_if #(.N(8), .WORDS(1)) w_if ();

  multiword_subtractor #(.N(4), .WORDS(4)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (u_if.slave)
  );

  multiword_subtractor #(.N(8), .WORDS(1)) dut1 (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (w_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then wait (bounded) for o_done; cyc counts edges after acceptance.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin, output int cyc);
    u_if.i_minuend    = a;
    u_if.i_subtrahend = b;
    u_if.i_borrow     = bin;
    u_if.i_start      = 1'b1;
    step();
    u_if.i_start = 1'b0;
    cyc = 0;
    while (u_if.o_done !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (u_if.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", u_if.o_ready); end
    checks++; if (u_if.o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", u_if.o_done); end
    checks++; if (u_if.o_difference !== 16'h0000) begin errors++; $display("FAIL reset_diff got %h want 0000", u_if.o_difference); end
    checks++; if ({u_if.o_borrow, u_if.o_overflow, u_if.o_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {u_if.o_borrow, u_if.o_overflow, u_if.o_zero}); end
  endtask

  task automatic test_basic();
    int cyc;
    run_op(16'h1234, 16'h0235, 1'b0, cyc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL basic_latency got %0d want 4", cyc); end
    checks++; if (u_if.o_difference !== 16'h0FFF) begin errors++; $display("FAIL basic_diff got %h want 0fff", u_if.o_difference); end
    checks++; if ({u_if.o_borrow, u_if.o_overflow, u_if.o_zero} !== 3'b000) begin errors++; $display("FAIL basic_flags got %b want 000", {u_if.o_borrow, u_if.o_overflow, u_if.o_zero}); end
    step();
    checks++; if (u_if.o_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", u_if.o_done); end
    checks++; if (u_if.o_difference !== 16'h0FFF) begin errors++; $display("FAIL basic_hold got %h want 0fff", u_if.o_difference); end
  endtask

  task automatic test_borrow();
    int cyc;
    run_op(16'h0000, 16'h0001, 1'b0, cyc);
    checks++; if (u_if.o_difference !== 16'hFFFF) begin errors++; $display("FAIL borrow1_diff got %h want ffff", u_if.o_difference); end
    checks++; if ({u_if.o_borrow, u_if.o_overflow, u_if.o_zero} !== 3'b100) begin errors++; $display("FAIL borrow1_flags got %b want 100", {u_if.o_borrow, u_if.o_overflow, u_if.o_zero}); end
    step();
    run_op(16'h0000, 16'h0000, 1'b1, cyc);
    checks++; if (u_if.o_difference !== 16'hFFFF) begin errors++; $display("FAIL borrowin_diff got %h want ffff", u_if.o_difference); end
    checks++; if (u_if.o_borrow !== 1'b1) begin errors++; $display("FAIL borrowin_borrow got %b want 1", u_if.o_borrow); end
    step();
  endtask

  task automatic test_overflow();
    int cyc;
    run_op(16'h8000, 16'h0001, 1'b0, cyc);
    checks++; if (u_if.o_difference !== 16'h7FFF) begin errors++; $display("FAIL ovf1_diff got %h want 7fff", u_if.o_difference); end
    checks++; if ({u_if.o_borrow, u_if.o_overflow} !== 2'b01) begin errors++; $display("FAIL ovf1_flags got %b want 01", {u_if.o_borrow, u_if.o_overflow}); end
    step();
    run_op(16'h7FFF, 16'hFFFF, 1'b0, cyc);
    checks++; if (u_if.o_difference !== 16'h8000) begin errors++; $display("FAIL ovf2_diff got %h want 8000", u_if.o_difference); end
    checks++; if ({u_if.o_borrow, u_if.o_overflow} !== 2'b11) begin errors++; $display("FAIL ovf2_flags got %b want 11", {u_if.o_borrow, u_if.o_overflow}); end
    step();
  endtask

  task automatic test_back_to_back();
    int cyc;
    int dones;
    run_op(16'h5A5A, 16'h5A5A, 1'b0, cyc);
    checks++; if (u_if.o_difference !== 16'h0000) begin errors++; $display("FAIL zero_diff got %h want 0000", u_if.o_difference); end
    checks++; if ({u_if.o_borrow, u_if.o_zero} !== 2'b01) begin errors++; $display("FAIL zero_flags got %b want 01", {u_if.o_borrow, u_if.o_zero}); end
    checks++; if (u_if.o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", u_if.o_ready); end
    u_if.i_minuend    = 16'h0003;
    u_if.i_subtrahend = 16'h0001;
    u_if.i_borrow     = 1'b0;
    u_if.i_start      = 1'b1;
    step();
    u_if.i_start = 1'b0;
    checks++; if (u_if.o_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got ready %b want 0", u_if.o_ready); end
    dones = 0;
    cyc = 0;
    while (u_if.o_done !== 1'b1 && cyc < 20) begin
      if (u_if.o_difference !== 16'h0000) begin
        checks++; errors++; $display("FAIL b2b_prev_hold got %h want 0000", u_if.o_difference);
      end
      step();
      cyc++;
    end
    checks++; if (cyc !== 4) begin errors++; $display("FAIL b2b_latency got %0d want 4", cyc); end
    checks++; if (u_if.o_difference !== 16'h0002) begin errors++; $display("FAIL b2b_diff got %h want 0002", u_if.o_difference); end
    for (int i = 0; i < 6; i++) begin
      if (u_if.o_done === 1'b1) dones++;
      step();
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL b2b_done_count got %0d want 1", dones); end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    u_if.i_minuend    = 16'h1234;
    u_if.i_subtrahend = 16'h0235;
    u_if.i_borrow     = 1'b0;
    u_if.i_start      = 1'b1;
    step();
    u_if.i_start = 1'b0;
    step();
    u_if.i_minuend    = 16'hFFFF;
    u_if.i_subtrahend = 16'h0000;
    u_if.i_borrow     = 1'b1;
    u_if.i_start      = 1'b1;
    step();
    u_if.i_start = 1'b0;
    cyc = 2;
    while (u_if.o_done !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    checks++; if (cyc !== 4) begin errors++; $display("FAIL ignore_latency got %0d want 4", cyc); end
    checks++; if (u_if.o_difference !== 16'h0FFF) begin errors++; $display("FAIL ignore_diff got %h want 0fff", u_if.o_difference); end
    step();
    checks++; if (u_if.o_ready !== 1'b1) begin errors++; $display("FAIL ignore_ready got %b want 1", u_if.o_ready); end
  endtask

  task automatic test_reset_mid_busy();
    int cyc;
    int dones;
    u_if.i_minuend    = 16'h00FF;
    u_if.i_subtrahend = 16'h0001;
    u_if.i_borrow     = 1'b0;
    u_if.i_start      = 1'b1;
    step();
    u_if.i_start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (u_if.o_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", u_if.o_ready); end
    checks++; if (u_if.o_done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", u_if.o_done); end
    checks++; if (u_if.o_difference !== 16'h0000) begin errors++; $display("FAIL midrst_diff got %h want 0000", u_if.o_difference); end
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (u_if.o_done === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", dones); end
    run_op(16'h0010, 16'h0001, 1'b0, cyc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL postrst_latency got %0d want 4", cyc); end
    checks++; if (u_if.o_difference !== 16'h000F) begin errors++; $display("FAIL postrst_diff got %h want 000f", u_if.o_difference); end
    checks++; if (u_if.o_borrow !== 1'b0) begin errors++; $display("FAIL postrst_borrow got %b want 0", u_if.o_borrow); end
    step();
  endtask

  task automatic test_words1();
    int cyc;
    w_if.i_minuend    = 8'h10;
    w_if.i_subtrahend = 8'h20;
    w_if.i_borrow     = 1'b0;
    w_if.i_start      = 1'b1;
    step();
    w_if.i_start = 1'b0;
    cyc = 0;
    while (w_if.o_done !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    checks++; if (cyc !== 1) begin errors++; $display("FAIL w1_latency got %0d want 1", cyc); end
    checks++; if (w_if.o_difference !== 8'hF0) begin errors++; $display("FAIL w1_diff got %h want f0", w_if.o_difference); end
    checks++; if ({w_if.o_borrow, w_if.o_overflow, w_if.o_zero} !== 3'b100) begin errors++; $display("FAIL w1_flags got %b want 100", {w_if.o_borrow, w_if.o_overflow, w_if.o_zero}); end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    u_if.i_start = 1'b0; u_if.i_minuend = '0; u_if.i_subtrahend = '0; u_if.i_borrow = 1'b0;
    w_if.i_start = 1'b0; w_if.i_minuend = '0; w_if.i_subtrahend = '0; w_if.i_borrow = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_busy();
    test_words1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multiword_subtractor.md
Name: multiword_subtractor

Overview:
- Limb-serial, multi-precision subtractor: computes i_minuend - i_subtrahend - i_borrow over N*WORDS bits, one N-bit limb per clock, LSB limb first, with the borrow chained between limbs.
- Start/ready/done handshake; flags for borrow-out, signed overflow and zero.
- Wide subtraction costs one N-bit subtractor instead of an N*WORDS-bit combinational chain; sits in the ALU datapath beside the combinational subtractor.

Parameters:
- N, 4, limb width in bits (>=1)
- WORDS, 4, number of limbs (>=1); operand width W = N*WORDS

Ports:
- i_clock  input  1  system clock, all state updates on rising edge
- i_reset  input  1  synchronous active-high reset
- i_start  input  1  request; accepted only on a rising edge where o_ready=1
- i_minuend  input  W  minuend, sampled on acceptance
- i_subtrahend  input  W  subtrahend, sampled on acceptance
- i_borrow  input  1  borrow-in for chaining, sampled on acceptance
- o_ready  output  1  1 when idle and able to accept i_start
- o_done  output  1  one-cycle pulse: results valid
- o_difference  output  W  result, held stable until next acceptance
- o_borrow  output  1  unsigned borrow-out (minuend < subtrahend + borrow-in)
- o_overflow  output  1  two's-complement signed overflow of the W-bit result
- o_zero  output  1  1 when o_difference == 0

Behaviour:
- States: IDLE, BUSY. o_ready = (state == IDLE).
- Reset (synchronous, any state including mid-BUSY):
  - state -> IDLE, limb index -> 0.
  - o_difference, o_borrow, o_overflow, o_zero, o_done -> 0.
  - An in-flight operation is discarded without o_done.
- Acceptance at edge k (IDLE, i_start=1):
  - Latch both operands and i_borrow into internal registers; index -> 0; state -> BUSY.
  - Previous result outputs remain unchanged until completion.
- BUSY, each edge:
  - limb j = index: {b, d} = A[j] - B[j] - borrow_reg, computed at N+1 bits.
  - d is written to result limb j; borrow_reg <- b; index++.
- After edge k+WORDS (last limb written), state -> IDLE.
  - o_difference, o_borrow, o_overflow and o_zero are updated with the final values on that same edge.
  - o_done is 1 for exactly that one cycle.
- Latency: o_done high in the cycle following edge k+WORDS. WORDS=1 completes in one BUSY cycle.
- o_overflow = (A[W-1] != B[W-1]) && (D[W-1] != A[W-1]), using the latched operands and the final result.
- o_zero is computed from the full final result, not per limb.
- i_start while BUSY is ignored; no queuing.
- Back-to-back: i_start=1 while o_done=1 is accepted on that edge (o_ready=1), so operations may run with no idle gap.
- Inputs other than i_start/i_reset are don't-care outside the acceptance edge; changing them mid-operation has no effect.
- Wrap-around: the result is modulo 2^W; the index never exceeds WORDS-1.

Test Plan:
- N=4, WORDS=4, A=0x1234, B=0x0235, borrow-in 0 -> o_done 4 cycles after the accept edge; difference 0x0FFF, borrow 0, overflow 0, zero 0.
- A=0x0000, B=0x0001 -> 0xFFFF, borrow 1, overflow 0, zero 0. Separately A=0x0000, B=0x0000, borrow-in 1 -> 0xFFFF, borrow 1.
- A=0x8000, B=0x0001 -> 0x7FFF, borrow 0, overflow 1. Separately A=0x7FFF, B=0xFFFF -> 0x8000, borrow 1, overflow 1.
- A=B=0x5A5A -> 0x0000, zero 1, borrow 0. Then a second i_start held high in the o_done cycle with A=0x0003, B=0x0001 -> accepted immediately; 0x0002 four cycles later, exactly one o_done per operation.
- Pulse i_start while BUSY with different operands -> ignored, the original result is delivered. Assert i_reset for one cycle at BUSY index 2 -> no o_done, all outputs 0, o_ready 1 on the next cycle, and a new operation completes correctly.
- WORDS=1, N=8: 0x10 - 0x20 -> 0xF0, borrow 1, o_done one cycle after acceptance.
